// File: rtl/vsync_driver_pkg.sv
// Shared VGA vertical timing constants and FSM state type.
// Also carries the horizontal line length used by the line driver.
package vsync_driver_pkg;

   localparam int VS_LINES    = 2;
   localparam int VBP_LINES   = 29;
   localparam int VDISP_LINES = 480;
   localparam int VFP_LINES   = 10;
   localparam int SCALE       = 5;
   localparam int H_LINE_CLKS = 1600;
   localparam int VROWS       = VDISP_LINES / SCALE;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SYNC        = 3'd1,
      ST_BACK_PORCH  = 3'd2,
      ST_DISPLAY     = 3'd3,
      ST_FRONT_PORCH = 3'd4
   } vstate_t;

   // Last line index of each phase; the counter never goes past it.
   function automatic logic [8:0] phase_last(input vstate_t s);
      logic [8:0] v;
      v = 9'd0;
      unique case (s)
         ST_SYNC:        v = 9'(VS_LINES - 1);
         ST_BACK_PORCH:  v = 9'(VBP_LINES - 1);
         ST_DISPLAY:     v = 9'(VDISP_LINES - 1);
         ST_FRONT_PORCH: v = 9'(VFP_LINES - 1);
         default:        v = 9'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vsync_driver_vpixel_controller.sv
// Vertical row scaler: each displayed row index spans SCALE lines.
// Held at zero whenever the current line is not visible.
module vpixel_controller
   import vsync_driver_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       new_line,
   input  logic       display_en,
   output logic [6:0] vpixel
);

   localparam logic [2:0] SUB_LAST = 3'(SCALE - 1);
   localparam logic [6:0] ROW_LAST = 7'(VROWS - 1);

   logic [2:0] r_sub;
   logic [6:0] r_vpixel;

   // The wrap after the last row lands on the line that leaves DISPLAY.
   always_ff @(posedge clk) begin
      if (reset || !display_en) begin
         r_sub    <= 3'd0;
         r_vpixel <= 7'd0;
      end else if (new_line) begin
         if (r_sub == SUB_LAST) begin
            r_sub    <= 3'd0;
            r_vpixel <= (r_vpixel == ROW_LAST) ? 7'd0 : r_vpixel + 7'd1;
         end else begin
            r_sub <= r_sub + 3'd1;
         end
      end
   end

   assign vpixel = r_vpixel;

endmodule

// File: rtl/vsync_driver.sv
// Vertical sync generator: walks sync/porch/display phases one line
// at a time, advancing only on new_line pulses from the line driver.
module vsync_driver
   import vsync_driver_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       new_line,
   output logic       vsync,
   output logic [6:0] vpixel,
   output logic       display_en,
   output logic       new_frame
);

   vstate_t    r_state;
   vstate_t    w_state_nxt;
   logic [8:0] r_line_cnt;
   logic [8:0] w_line_nxt;
   logic       w_frame_nxt;
   logic       w_last;
   logic       r_vsync;
   logic       r_display_en;
   logic       r_new_frame;

   assign w_last = (r_line_cnt == phase_last(r_state));

   always_comb begin
      w_state_nxt = r_state;
      w_line_nxt  = r_line_cnt;
      w_frame_nxt = 1'b0;
      if (new_line) begin
         w_line_nxt = w_last ? 9'd0 : r_line_cnt + 9'd1;
         unique case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_SYNC;
               w_line_nxt  = 9'd0;
               w_frame_nxt = 1'b1;
            end
            ST_SYNC:
               if (w_last) w_state_nxt = ST_BACK_PORCH;
            ST_BACK_PORCH:
               if (w_last) w_state_nxt = ST_DISPLAY;
            ST_DISPLAY:
               if (w_last) w_state_nxt = ST_FRONT_PORCH;
            ST_FRONT_PORCH:
               if (w_last) begin
                  w_state_nxt = ST_SYNC;
                  w_frame_nxt = 1'b1;
               end
            default: begin
               w_state_nxt = ST_IDLE;
               w_line_nxt  = 9'd0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they move together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_line_cnt   <= 9'd0;
         r_vsync      <= 1'b1;
         r_display_en <= 1'b0;
         r_new_frame  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_line_cnt   <= w_line_nxt;
         r_vsync      <= (w_state_nxt != ST_SYNC);
         r_display_en <= (w_state_nxt == ST_DISPLAY);
         r_new_frame  <= w_frame_nxt;
      end
   end

   vpixel_controller u_vpixel (
      .clk        (clk),
      .reset      (reset),
      .new_line   (new_line),
      .display_en (r_display_en),
      .vpixel     (vpixel)
   );

   assign vsync      = r_vsync;
   assign display_en = r_display_en;
   assign new_frame  = r_new_frame;

endmodule

// File: doc/vsync_driver.md
VSYNC_DRIVER -- requirements
Module: vsync_driver

Interface
REQ-001 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 new_line  input  1  one-cycle pulse from hsync_driver at the start of each 1600-clock horizontal line.
REQ-004 vsync  output  1  vertical sync to VGA connector; active low; registered.
REQ-005 vpixel  output  7  display row index after 5x vertical scaling, 0..95; registered.
REQ-006 display_en  output  1  high while the current line is a visible line; registered.
REQ-007 new_frame  output  1  one-cycle pulse marking frame start; registered.
REQ-008 Parameters: VS_LINES = 2 (sync), VBP_LINES = 29 (back porch), VDISP_LINES = 480 (display), VFP_LINES = 10 (front porch), SCALE = 5.
- Frame total: 521 lines.

Function
REQ-009 FSM states: IDLE, SYNC, BACK_PORCH, DISPLAY, FRONT_PORCH.
REQ-010 State, line counter and outputs change only in the cycle after a sampled new_line; no other input event advances them.
REQ-011 IDLE -> SYNC on the first new_line after reset; line counter = 0.
REQ-012 Phase transitions occur on the new_line that ends the phase, i.e. when line counter = phase length - 1; the counter clears to 0 at each transition:
- SYNC -> BACK_PORCH
- BACK_PORCH -> DISPLAY
- DISPLAY -> FRONT_PORCH
- FRONT_PORCH -> SYNC
REQ-013 Line counter is 9 bits wide and never exceeds phase length - 1.
REQ-014 vsync = 0 exactly while state is SYNC; 1 in all other states.
REQ-015 display_en = 1 exactly while state is DISPLAY.
REQ-016 In DISPLAY, a 3-bit sub-counter counts 0..SCALE-1 per new_line.
- vpixel increments when the sub-counter wraps from 4 to 0.
- vpixel = 0 on the first display line and 95 on the last (line 479).
REQ-017 vpixel = 0 and the sub-counter = 0 in every state except DISPLAY; both clear on entry to DISPLAY.
REQ-018 new_frame = 1 for exactly one cycle, in the same cycle vsync first goes low (every IDLE->SYNC and FRONT_PORCH->SYNC); 0 otherwise.
REQ-019 Output latency: exactly 1 clock after the new_line cycle; all outputs change together.
REQ-020 new_line held high for several consecutive cycles counts as one event per high cycle; no edge detection is applied. Upstream guarantees single-cycle pulses.

Reset
REQ-021 While reset = 1, the block SHALL hold: state IDLE, counters 0, vsync = 1, vpixel = 0, display_en = 0, new_frame = 0.
REQ-022 reset has priority over new_line in the same cycle.
REQ-023 Reset asserted mid-frame returns the block to IDLE on the next edge; no partial frame resumes.

Structure
REQ-024 VGA timing constants SHALL reside in the shared vga_params include, reused by hsync_driver:
- VS_LINES, VBP_LINES, VDISP_LINES, VFP_LINES, SCALE
- H_LINE_CLKS = 1600
REQ-025 The FSM and line counter SHALL live in vsync_driver.
REQ-026 Row scaling SHALL be one sub-module, vpixel_controller, mirroring hpixel_controller.
- Inputs: clk, reset, new_line, display_en.
- Output: vpixel.
REQ-027 State encoding SHALL be localparams; no latches and no combinational output paths.

Verification
REQ-028 The bench SHALL instantiate hsync_driver and vsync_driver together.
- clk period 20 ns; reset released at 74 ns.
- Required: first new_frame 1 clock after the first new_line; vsync low for exactly 2 x 1600 = 3200 clocks.
REQ-029 Full frame:
- vsync falling-edge spacing = 521 x 1600 = 833600 clocks (16.672 ms).
- display_en high for 480 lines, starting 31 lines after the vsync fall.
REQ-030 Row index: across DISPLAY, vpixel takes each value 0..95 for exactly 5 consecutive lines, then returns to 0 in FRONT_PORCH.
REQ-031 Reset mid-display (line 200 of DISPLAY):
- Next edge: vsync = 1, display_en = 0, vpixel = 0.
- After release, the next new_line restarts SYNC and pulses new_frame.
REQ-032 Reset coincident with new_line: block stays IDLE and no new_frame pulse occurs.
REQ-033 A directed new_line stub at 1 pulse per 4 clocks SHALL show identical line-count sequencing, confirming progress depends only on new_line.
